multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 40 ++++
 rtl/multicycle_control.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Bundle of handshake and control signals for multicycle_control.
//   Opcode, Zero, stall : inputs to the controller (instruction register, ALU flag, freeze)
//   PC_w .. instr_done  : one-bit datapath controls and status
//   ALU_op              : 00 ADDU, 01 SUBU, 10 R-type funct, 11 SLTI
//   state               : current FSM state (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4)
// slave  : controller side (drives the controls)
// master : datapath / bench side (drives Opcode, Zero, stall)
interface multicycle_control_if #(
    parameter int OP_W = 6
);
    logic [OP_W-1:0] Opcode;
    logic            Zero;
    logic            stall;
    logic            PC_w;
    logic            IR_w;
    logic            IorD;
    logic            Reg_dst;
    logic            Reg_w;
    logic            ALU_src;
    logic            Mem_w;
    logic            Mem_r;
    logic            Mem_to_reg;
    logic            Branch;
    logic            illegal;
    logic            instr_done;
    logic [1:0]      ALU_op;
    logic [2:0]      state;

    modport slave (
        input  Opcode, Zero, stall,
        output PC_w, IR_w, IorD, Reg_dst, Reg_w, ALU_src, Mem_w, Mem_r,
               Mem_to_reg, Branch, illegal, instr_done, ALU_op, state
    );

    modport master (
        output Opcode, Zero, stall,
        input  PC_w, IR_w, IorD, Reg_dst, Reg_w, ALU_src, Mem_w, Mem_r,
               Mem_to_reg, Branch, illegal, instr_done, ALU_op, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM (FETCH -> DECODE -> EXEC -> [MEM] -> [WB]).
// Memory accesses in FETCH and MEM last MEM_LAT+1 cycles, timed by a 4-bit
// counter that clears on entry to each state.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (wins over stall)
//   bus  : multicycle_control_if.slave (Opcode/Zero/stall in, controls out)
// Parameters: OP_W opcode width (>= 6), MEM_LAT extra memory wait cycles (0..15).
// Optional feature: define MULTICYCLE_BRANCH_EN to make BEQ (000100) legal.
module multicycle_control #(
    parameter int OP_W    = 6,
    parameter int MEM_LAT = 2
) (
    input logic                 clk,
    input logic                 rst,
    multicycle_control_if.slave bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    localparam logic [OP_W-1:0] OP_R     = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b010001);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b010000);
    localparam logic [OP_W-1:0] OP_SUBIU = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b101010);
`ifdef MULTICYCLE_BRANCH_EN
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
`endif

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        logic ok;
        ok = (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_SUBIU) || (op == OP_SLTI);
`ifdef MULTICYCLE_BRANCH_EN
        ok = ok || (op == OP_BEQ);
`endif
        return ok;
    endfunction

    logic [2:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            last;
    logic            wr_en;

    assign last  = (cnt_q == LAT);
    // Write pulses are suppressed while frozen; they replay on the first free cycle.
    assign wr_en = ~bus.stall;

`ifndef MULTICYCLE_BRANCH_EN
    logic unused_zero;
    assign unused_zero = bus.Zero;
`endif

    // Next-state, counter and opcode register
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        if (!bus.stall) begin
            case (state_q)
                S_FETCH: begin
                    if (last) begin
                        state_d = S_DECODE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_DECODE: begin
                    op_d    = bus.Opcode;
                    state_d = is_legal(bus.Opcode) ? S_EXEC : S_FETCH;
                    cnt_d   = 4'd0;
                end
                S_EXEC: begin
                    cnt_d = 4'd0;
                    if (op_q == OP_LW || op_q == OP_SW)
                        state_d = S_MEM;
`ifdef MULTICYCLE_BRANCH_EN
                    else if (op_q == OP_BEQ)
                        state_d = S_FETCH;
`endif
                    else
                        state_d = S_WB;
                end
                S_MEM: begin
                    if (last) begin
                        state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = S_FETCH;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= 4'd0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    // Output decode
    always_comb begin
        bus.PC_w       = 1'b0;
        bus.IR_w       = 1'b0;
        bus.IorD       = 1'b0;
        bus.Reg_dst    = 1'b0;
        bus.Reg_w      = 1'b0;
        bus.ALU_src    = 1'b0;
        bus.Mem_w      = 1'b0;
        bus.Mem_r      = 1'b0;
        bus.Mem_to_reg = 1'b0;
        bus.Branch     = 1'b0;
        bus.illegal    = 1'b0;
        bus.instr_done = 1'b0;
        bus.ALU_op     = 2'b00;
        bus.state      = state_q;
        case (state_q)
            S_FETCH: begin
                bus.Mem_r = 1'b1;
                if (last) begin
                    bus.IR_w = wr_en;
                    bus.PC_w = wr_en;
                end
            end
            S_DECODE: begin
                // op_q is only loaded at the end of DECODE, so legality
                // is judged on the instruction register output directly.
                bus.illegal = ~is_legal(bus.Opcode);
            end
            S_EXEC: begin
                if (op_q == OP_R) begin
                    bus.ALU_op = 2'b10;
                end else if (op_q == OP_LW || op_q == OP_SW) begin
                    bus.ALU_src = 1'b1;
                end else if (op_q == OP_SUBIU) begin
                    bus.ALU_op  = 2'b01;
                    bus.ALU_src = 1'b1;
                end else if (op_q == OP_SLTI) begin
                    bus.ALU_op  = 2'b11;
                    bus.ALU_src = 1'b1;
                end
`ifdef MULTICYCLE_BRANCH_EN
                else if (op_q == OP_BEQ) begin
                    bus.ALU_op     = 2'b01;
                    bus.Branch     = 1'b1;
                    bus.PC_w       = bus.Zero & wr_en;
                    bus.instr_done = wr_en;
                end
`endif
            end
            S_MEM: begin
                bus.IorD  = 1'b1;
                bus.Mem_r = (op_q == OP_LW);
                if (op_q == OP_SW && last) begin
                    bus.Mem_w      = wr_en;
                    bus.instr_done = wr_en;
                end
            end
            S_WB: begin
                bus.Reg_w      = wr_en;
                bus.Reg_dst    = (op_q == OP_R);
                bus.Mem_to_reg = (op_q == OP_LW);
                bus.instr_done = wr_en;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control at MEM_LAT=2. Each cycle the whole
// output set is packed into one word and compared with a hand-built word.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if #(.OP_W(6)) bus ();

    multicycle_control #(.OP_W(6), .MEM_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Packed output word: {PC_w, IR_w, IorD, Reg_dst, Reg_w, ALU_src, Mem_w,
    //                      Mem_r, Mem_to_reg, Branch, illegal, instr_done, ALU_op, state}
    localparam logic [16:0] M_PCW  = 17'h10000;
    localparam logic [16:0] M_IRW  = 17'h08000;
    localparam logic [16:0] M_IORD = 17'h04000;
    localparam logic [16:0] M_RDST = 17'h02000;
    localparam logic [16:0] M_RW   = 17'h01000;
    localparam logic [16:0] M_ASRC = 17'h00800;
    localparam logic [16:0] M_MW   = 17'h00400;
    localparam logic [16:0] M_MR   = 17'h00200;
    localparam logic [16:0] M_M2R  = 17'h00100;
    localparam logic [16:0] M_BR   = 17'h00080;
    localparam logic [16:0] M_ILL  = 17'h00040;
    localparam logic [16:0] M_DONE = 17'h00020;
    localparam logic [16:0] A_SUB  = 17'h00008;
    localparam logic [16:0] A_R    = 17'h00010;
    localparam logic [16:0] A_SLT  = 17'h00018;
    localparam logic [16:0] S_F    = 17'd0;
    localparam logic [16:0] S_D    = 17'd1;
    localparam logic [16:0] S_E    = 17'd2;
    localparam logic [16:0] S_M    = 17'd3;
    localparam logic [16:0] S_W    = 17'd4;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b010001;
    localparam logic [5:0] OP_SW    = 6'b010000;
    localparam logic [5:0] OP_SUBIU = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b101010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    logic [16:0] obs;
    assign obs = {bus.PC_w, bus.IR_w, bus.IorD, bus.Reg_dst, bus.Reg_w, bus.ALU_src,
                  bus.Mem_w, bus.Mem_r, bus.Mem_to_reg, bus.Branch, bus.illegal,
                  bus.instr_done, bus.ALU_op, bus.state};

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %05h expected %05h", tag, got, want);
    endtask

    // Compare outputs mid-cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [16:0] want);
        @(negedge clk);
        check_eq(tag, obs, want);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch3(input string tag);
        cyc({tag, "_f0"}, S_F | M_MR);
        cyc({tag, "_f1"}, S_F | M_MR);
        cyc({tag, "_f2"}, S_F | M_MR | M_IRW | M_PCW);
    endtask

    initial begin
        bus.Opcode = OP_R;
        bus.Zero   = 1'b0;
        bus.stall  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // R-type: states 0,0,0,1,2,4; reset-state check is the first FETCH cycle
        cyc("reset_state", S_F | M_MR);
        cyc("r_f1", S_F | M_MR);
        cyc("r_f2", S_F | M_MR | M_IRW | M_PCW);
        cyc("r_dec", S_D);
        cyc("r_exec", S_E | A_R);
        cyc("r_wb", S_W | M_RW | M_RDST | M_DONE);

        // LW: 9 cycles, Mem_r through all MEM cycles, Mem_to_reg in WB
        bus.Opcode = OP_LW;
        fetch3("lw");
        cyc("lw_dec", S_D);
        cyc("lw_exec", S_E | M_ASRC);
        cyc("lw_mem0", S_M | M_IORD | M_MR);
        cyc("lw_mem1", S_M | M_IORD | M_MR);
        cyc("lw_mem2", S_M | M_IORD | M_MR);
        cyc("lw_wb", S_W | M_RW | M_M2R | M_DONE);

        // SW: 8 cycles, single Mem_w on last MEM cycle
        bus.Opcode = OP_SW;
        fetch3("sw");
        cyc("sw_dec", S_D);
        cyc("sw_exec", S_E | M_ASRC);
        cyc("sw_mem0", S_M | M_IORD);
        cyc("sw_mem1", S_M | M_IORD);
        cyc("sw_mem2", S_M | M_IORD | M_MW | M_DONE);

        // SUBIU
        bus.Opcode = OP_SUBIU;
        fetch3("subiu");
        cyc("subiu_dec", S_D);
        cyc("subiu_exec", S_E | A_SUB | M_ASRC);
        cyc("subiu_wb", S_W | M_RW | M_DONE);

        // SLTI
        bus.Opcode = OP_SLTI;
        fetch3("slti");
        cyc("slti_dec", S_D);
        cyc("slti_exec", S_E | A_SLT | M_ASRC);
        cyc("slti_wb", S_W | M_RW | M_DONE);

        // Illegal opcode: flag in DECODE, back to FETCH without writes
        bus.Opcode = OP_BAD;
        fetch3("ill");
        cyc("ill_dec", S_D | M_ILL);
        cyc("ill_after0", S_F | M_MR);
        cyc("ill_after1", S_F | M_MR);
        cyc("ill_after2", S_F | M_MR | M_IRW | M_PCW);

`ifdef MULTICYCLE_BRANCH_EN
        // BEQ taken / not taken, 5 cycles each
        bus.Opcode = OP_BEQ;
        bus.Zero   = 1'b1;
        cyc("beq_t_dec", S_D);
        cyc("beq_t_exec", S_E | A_SUB | M_BR | M_PCW | M_DONE);
        bus.Zero = 1'b0;
        fetch3("beq_n");
        cyc("beq_n_dec", S_D);
        cyc("beq_n_exec", S_E | A_SUB | M_BR | M_DONE);
`else
        // Without the branch option, BEQ encoding is illegal and Zero is ignored
        bus.Opcode = OP_BEQ;
        bus.Zero   = 1'b1;
        cyc("beq_ill_dec", S_D | M_ILL);
        bus.Zero = 1'b0;
`endif

        // Stall on the final FETCH cycle for 3 cycles, then one IR_w pulse;
        // then a stalled WB keeps Reg_dst but drops Reg_w/instr_done.
        bus.Opcode = OP_R;
        cyc("stl_f0", S_F | M_MR);
        cyc("stl_f1", S_F | M_MR);
        bus.stall = 1'b1;
        cyc("stl_hold0", S_F | M_MR);
        cyc("stl_hold1", S_F | M_MR);
        cyc("stl_hold2", S_F | M_MR);
        bus.stall = 1'b0;
        cyc("stl_release", S_F | M_MR | M_IRW | M_PCW);
        cyc("stl_dec", S_D);
        cyc("stl_exec", S_E | A_R);
        bus.stall = 1'b1;
        cyc("stl_wb_hold", S_W | M_RDST);
        bus.stall = 1'b0;
        cyc("stl_wb", S_W | M_RW | M_RDST | M_DONE);

        // Reset in the middle of LW MEM
        bus.Opcode = OP_LW;
        fetch3("rlw");
        cyc("rlw_dec", S_D);
        cyc("rlw_exec", S_E | M_ASRC);
        cyc("rlw_mem0", S_M | M_IORD | M_MR);
        rst = 1'b1;
        cyc("rlw_mem1", S_M | M_IORD | M_MR);
        rst = 1'b0;
        cyc("rlw_after_rst", S_F | M_MR);
        cyc("rlw_f1", S_F | M_MR);
        cyc("rlw_f2", S_F | M_MR | M_IRW | M_PCW);

        // Reset while stalled on the final SW MEM cycle: no Mem_w, counter restarts
        bus.Opcode = OP_SW;
        cyc("rsw_dec", S_D);
        cyc("rsw_exec", S_E | M_ASRC);
        cyc("rsw_mem0", S_M | M_IORD);
        cyc("rsw_mem1", S_M | M_IORD);
        bus.stall = 1'b1;
        rst       = 1'b1;
        cyc("rsw_mem2_stall", S_M | M_IORD);
        rst       = 1'b0;
        bus.stall = 1'b0;
        cyc("rsw_after_rst", S_F | M_MR);
        cyc("rsw_f1", S_F | M_MR);
        cyc("rsw_f2", S_F | M_MR | M_IRW | M_PCW);
        cyc("rsw_dec2", S_D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
